rbzero_pov_ctrl: RTL and testbench
==================================

RBZERO_POV_CTRL -- requirements
Module: rbzero_pov_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset:
  clk  in  1  system clock; all state changes on the rising edge.
  reset  in  1  synchronous, active-high.
REQ-002 The block SHALL have these ports:
  spi_sclk  in  1  SPI clock, asynchronous to clk, idle low (mode 0).
  spi_mosi  in  1  SPI data, MSB first.
  spi_ss_n  in  1  SPI select, active-low, asynchronous.
  frame_start  in  1  one-cycle pulse from the raycaster at the start of vertical blank.
  player_x, player_y  out  16 each  live player position, unsigned Q6.10.
  facing_x, facing_y  out  16 each  live facing vector, signed Q6.10.
  vplane_x, vplane_y  out  16 each  live view plane, signed Q6.10.
  sky_rgb, floor_rgb  out  6 each  live background colours.
  pending  out  1  staged data is awaiting commit.
  pov_update  out  1  one-cycle pulse: live registers changed this cycle.

Function
REQ-003 spi_sclk, spi_mosi and spi_ss_n SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-004 spi_sclk SHALL be sampled at no more than clk/4; the block is not required to handle faster SPI clocks.
REQ-005 A falling edge of synchronized ss_n SHALL clear the 5-bit bit counter and the 20-bit shift register.
REQ-006 On each synchronized sclk rising edge while ss_n is low, the block SHALL shift mosi into the LSB and increment the bit counter; the counter SHALL saturate at 31.
REQ-007 A transaction SHALL be bits[19:16] = address and bits[15:0] = data.
REQ-008 On the synchronized ss_n rising edge, the block SHALL accept the transaction only if the bit count equals exactly 20; any other count SHALL be discarded with no state change.
REQ-009 An accepted transaction SHALL update the staging register as follows, and SHALL set pending:
  0 player_x; 1 player_y; 2 facing_x; 3 facing_y; 4 vplane_x; 5 vplane_y.
  6 sky_rgb = data[5:0], floor_rgb = data[13:8].
REQ-010 Addresses 7-15 SHALL be ignored and SHALL leave pending unchanged.
REQ-011 On a cycle with frame_start=1 and pending=1, the block SHALL copy all staging registers to the live outputs, visible on the next cycle. On that next cycle it SHALL clear pending and assert pov_update for exactly one cycle.
REQ-012 frame_start with pending=0 SHALL leave all outputs unchanged and SHALL not pulse pov_update.
REQ-013 If an accept (REQ-008) and a commit (REQ-011) occur on the same cycle, the commit SHALL use the staging contents from before the write. The new write SHALL update staging and leave pending=1 for the next frame.
REQ-014 Multiple accepted writes before a commit SHALL all be kept; the last write to each address wins.
REQ-015 Live outputs SHALL never change except on a commit or on reset.

Reset
REQ-016 While reset=1, the staging and live registers SHALL load these values: player_x=0x1800, player_y=0x1800, facing_x=0x0000, facing_y=0xFC00 (-1.0), vplane_x=0x0200 (0.5), vplane_y=0x0000, sky_rgb=0x15, floor_rgb=0x2A.
REQ-017 While reset=1, pending=0, pov_update=0, the bit counter=0, the shift register=0, and all synchronizer flops=idle (sclk=0, ss_n=1).
REQ-018 Reset asserted mid-transaction SHALL abandon that transaction. After reset, no accept SHALL occur until a fresh ss_n falling edge is seen.

Configuration
REQ-019 The macro RBZERO_POV_VSYNC_LATCH_EN selects commit behaviour.
  Defined: frame-synchronous double-buffering exactly as REQ-011 to REQ-014.
  Undefined: an accepted write SHALL update staging and the live output on the same edge. pov_update SHALL pulse on the following cycle, pending SHALL be tied 0, and frame_start SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios (macro defined unless noted):
  V1: Reset, then no SPI -> all outputs at REQ-016 values; pending=0; pov_update never pulses.
  V2: Write addr 0 data 0x2345, then frame_start -> pending=1 after ss_n rises, player_x still 0x1800. The cycle after frame_start, player_x=0x2345, pending=0, pov_update=1 for one cycle.
  V3: Send 19 bits then 21 bits (addr 0, 0xFFFF), then frame_start -> pending stays 0; player_x stays 0x1800.
  V4: Write addr 6 data 0x0C33 and addr 2 data 0x0400 in separate frames, then frame_start -> sky_rgb=0x33, floor_rgb=0x0C, facing_x=0x0400, one pov_update pulse.
  V5: Align the addr 1 0x1111 accept with frame_start while staging has player_y=0x2222 pending -> live player_y=0x2222, pending=1. The next frame_start gives player_y=0x1111.
  V6: Macro undefined, write addr 4 data 0x0300 -> vplane_x=0x0300 with no frame_start; pending=0; one pov_update pulse.

Source files
------------

// File: rtl/rbzero_pov_ctrl.sv
// rbzero_pov_ctrl -- SPI-loaded point-of-view registers for the raycaster.
//
// An SPI master (mode 0, MSB first) writes 20-bit words {addr[3:0], data[15:0]}
// into a staging bank. Depending on the build option, the staging bank is
// copied to the live outputs either at the next frame_start (double-buffered)
// or immediately on each accepted write.
//
// Build option:
//   RBZERO_POV_VSYNC_LATCH_EN  defined   : live registers change only when
//                                          frame_start arrives while a write
//                                          is pending.
//                              undefined : every accepted write reaches the
//                                          live outputs at once; pending is 0
//                                          and frame_start is ignored.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   spi_sclk/mosi/ss_n      raw SPI pins, asynchronous to clk (sclk <= clk/4)
//   frame_start             one-cycle pulse at the start of vertical blank
//   player_x/y              live player position, unsigned Q6.10
//   facing_x/y, vplane_x/y  live facing and view-plane vectors, signed Q6.10
//   sky_rgb, floor_rgb      live background colours
//   pending                 staged data is waiting for the next commit
//   pov_update              one-cycle pulse in the cycle live registers changed
//
// Handshake: there is no valid/ready pair here. A transaction is a complete
// ss_n low period; it is accepted on the ss_n rising edge only when exactly 20
// sclk rising edges were counted, otherwise it is silently dropped.
module rbzero_pov_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  input  logic        frame_start,
  output logic [15:0] player_x,
  output logic [15:0] player_y,
  output logic [15:0] facing_x,
  output logic [15:0] facing_y,
  output logic [15:0] vplane_x,
  output logic [15:0] vplane_y,
  output logic [5:0]  sky_rgb,
  output logic [5:0]  floor_rgb,
  output logic        pending,
  output logic        pov_update
);

  localparam logic [15:0] RST_PLAYER_X = 16'h1800;
  localparam logic [15:0] RST_PLAYER_Y = 16'h1800;
  localparam logic [15:0] RST_FACING_X = 16'h0000;
  localparam logic [15:0] RST_FACING_Y = 16'hFC00;
  localparam logic [15:0] RST_VPLANE_X = 16'h0200;
  localparam logic [15:0] RST_VPLANE_Y = 16'h0000;
  localparam logic [5:0]  RST_SKY      = 6'h15;
  localparam logic [5:0]  RST_FLOOR    = 6'h2A;

  // ---------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_q, ss_q;
  // Edges are ignored until the synchronizers hold real pin values again
  // after reset, so the reset-idle values cannot fake an ss_n edge.
  logic [2:0] sync_warm;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      sync_warm <= 3'b000;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      ss_sync   <= {ss_sync[0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_q    <= sclk_sync[1];
      ss_q      <= ss_sync[1];
      sync_warm <= {sync_warm[1:0], 1'b1};
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, ss_fall, ss_rise;

  assign sclk_s    = sclk_sync[1];
  assign ss_s      = ss_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sync_warm[2] & sclk_s & ~sclk_q;
  assign ss_fall   = sync_warm[2] & ~ss_s & ss_q;
  assign ss_rise   = sync_warm[2] & ss_s & ~ss_q;

  // ---------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------
  logic [4:0]  bit_cnt;
  logic [19:0] shift_reg;
  // armed: a falling ss_n edge has been seen since reset or the last
  // transaction end; a transaction in flight across reset stays dead.
  logic        armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= 5'd0;
      shift_reg <= 20'd0;
      armed     <= 1'b0;
    end else if (ss_fall) begin
      bit_cnt   <= 5'd0;
      shift_reg <= 20'd0;
      armed     <= 1'b1;
    end else begin
      if (ss_rise) armed <= 1'b0;
      if (sclk_rise && !ss_s && armed) begin
        shift_reg <= {shift_reg[18:0], mosi_s};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  logic        accept;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;

  assign accept  = ss_rise && armed && (bit_cnt == 5'd20);
  assign wr_addr = shift_reg[19:16];
  assign wr_data = shift_reg[15:0];
  assign wr_en   = accept && (wr_addr <= 4'd6);

`ifdef RBZERO_POV_VSYNC_LATCH_EN
  // ---------------------------------------------------------------------
  // Double-buffered: staging bank, committed at frame_start
  // ---------------------------------------------------------------------
  logic [15:0] stg_player_x, stg_player_y, stg_facing_x, stg_facing_y;
  logic [15:0] stg_vplane_x, stg_vplane_y;
  logic [5:0]  stg_sky, stg_floor;
  logic        commit;

  assign commit = frame_start && pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_player_x <= RST_PLAYER_X;
      stg_player_y <= RST_PLAYER_Y;
      stg_facing_x <= RST_FACING_X;
      stg_facing_y <= RST_FACING_Y;
      stg_vplane_x <= RST_VPLANE_X;
      stg_vplane_y <= RST_VPLANE_Y;
      stg_sky      <= RST_SKY;
      stg_floor    <= RST_FLOOR;
      player_x     <= RST_PLAYER_X;
      player_y     <= RST_PLAYER_Y;
      facing_x     <= RST_FACING_X;
      facing_y     <= RST_FACING_Y;
      vplane_x     <= RST_VPLANE_X;
      vplane_y     <= RST_VPLANE_Y;
      sky_rgb      <= RST_SKY;
      floor_rgb    <= RST_FLOOR;
      pending      <= 1'b0;
      pov_update   <= 1'b0;
    end else begin
      pov_update <= commit;
      // Non-blocking reads here see the staging bank from before any write
      // landing on this same edge, so a coincident write waits a frame.
      if (commit) begin
        player_x  <= stg_player_x;
        player_y  <= stg_player_y;
        facing_x  <= stg_facing_x;
        facing_y  <= stg_facing_y;
        vplane_x  <= stg_vplane_x;
        vplane_y  <= stg_vplane_y;
        sky_rgb   <= stg_sky;
        floor_rgb <= stg_floor;
      end
      if (wr_en) begin
        case (wr_addr)
          4'd0:    stg_player_x <= wr_data;
          4'd1:    stg_player_y <= wr_data;
          4'd2:    stg_facing_x <= wr_data;
          4'd3:    stg_facing_y <= wr_data;
          4'd4:    stg_vplane_x <= wr_data;
          4'd5:    stg_vplane_y <= wr_data;
          default: begin
            stg_sky   <= wr_data[5:0];
            stg_floor <= wr_data[13:8];
          end
        endcase
      end
      if (wr_en)       pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end
`else
  // ---------------------------------------------------------------------
  // Immediate: accepted writes go straight to the live registers
  // ---------------------------------------------------------------------
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign pending = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      player_x   <= RST_PLAYER_X;
      player_y   <= RST_PLAYER_Y;
      facing_x   <= RST_FACING_X;
      facing_y   <= RST_FACING_Y;
      vplane_x   <= RST_VPLANE_X;
      vplane_y   <= RST_VPLANE_Y;
      sky_rgb    <= RST_SKY;
      floor_rgb  <= RST_FLOOR;
      pov_update <= 1'b0;
    end else begin
      // Pulse is high in the cycle the new value is first visible.
      pov_update <= wr_en;
      if (wr_en) begin
        case (wr_addr)
          4'd0:    player_x <= wr_data;
          4'd1:    player_y <= wr_data;
          4'd2:    facing_x <= wr_data;
          4'd3:    facing_y <= wr_data;
          4'd4:    vplane_x <= wr_data;
          4'd5:    vplane_y <= wr_data;
          default: begin
            sky_rgb   <= wr_data[5:0];
            floor_rgb <= wr_data[13:8];
          end
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_rbzero_pov_ctrl.sv
// Directed bench for rbzero_pov_ctrl. Covers both build options; the
// scenarios compiled in follow RBZERO_POV_VSYNC_LATCH_EN.
`timescale 1ns/1ps
module tb_rbzero_pov_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_mosi, spi_ss_n, frame_start;
  logic [15:0] player_x, player_y, facing_x, facing_y, vplane_x, vplane_y;
  logic [5:0]  sky_rgb, floor_rgb;
  logic        pending, pov_update;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  rbzero_pov_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_ss_n   (spi_ss_n),
    .frame_start(frame_start),
    .player_x   (player_x),
    .player_y   (player_y),
    .facing_x   (facing_x),
    .facing_y   (facing_y),
    .vplane_x   (vplane_x),
    .vplane_y   (vplane_y),
    .sky_rgb    (sky_rgb),
    .floor_rgb  (floor_rgb),
    .pending    (pending),
    .pov_update (pov_update)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Counts cycles with pov_update high, sampled away from the active edge.
  always @(negedge clk) if (pov_update === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic spi_shift(input logic [31:0] bits, input int n);
    spi_ss_n = 1'b0;
    #40;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
    #40;
  endtask

  task automatic spi_send(input logic [31:0] bits, input int n);
    spi_shift(bits, n);
    spi_ss_n = 1'b1;
    #120;
  endtask

  task automatic pulse_frame;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int p0;

  initial begin
    reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1; frame_start = 1'b0;
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(20);

    // V1: reset values, no update pulses
    check("rst_player_x", player_x, 32'h1800);
    check("rst_player_y", player_y, 32'h1800);
    check("rst_facing_x", facing_x, 32'h0000);
    check("rst_facing_y", facing_y, 32'hFC00);
    check("rst_vplane_x", vplane_x, 32'h0200);
    check("rst_vplane_y", vplane_y, 32'h0000);
    check("rst_sky",      sky_rgb,  32'h15);
    check("rst_floor",    floor_rgb, 32'h2A);
    check("rst_pending",  pending,  32'h0);
    check("rst_no_pulse", pulse_cnt, 32'd0);

`ifdef RBZERO_POV_VSYNC_LATCH_EN
    // frame_start with nothing pending does nothing
    pulse_frame();
    wait_cycles(3);
    check("idle_frame_pulse", pulse_cnt, 32'd0);

    // V2: single write, committed at frame_start
    spi_send({4'h0, 16'h2345}, 20);
    check("v2_pending", pending, 32'h1);
    check("v2_staged_only", player_x, 32'h1800);
    p0 = pulse_cnt;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("v2_player_x", player_x, 32'h2345);
    check("v2_pending_clr", pending, 32'h0);
    check("v2_pov_update", pov_update, 32'h1);
    wait_cycles(4);
    check("v2_one_pulse", pulse_cnt - p0, 32'd1);

    // V3: 19 and 21 bit transactions are dropped
    spi_send({4'h0, 16'hFFFF}, 19);
    spi_send({5'h0, 16'hFFFF}, 21);
    check("v3_pending", pending, 32'h0);
    p0 = pulse_cnt;
    pulse_frame();
    wait_cycles(3);
    check("v3_player_x", player_x, 32'h2345);
    check("v3_no_pulse", pulse_cnt - p0, 32'd0);

    // address 7 is ignored
    spi_send({4'h7, 16'h1234}, 20);
    check("addr7_pending", pending, 32'h0);

    // V4: two writes, one commit
    spi_send({4'h6, 16'h0C33}, 20);
    spi_send({4'h2, 16'h0400}, 20);
    check("v4_sky_before", sky_rgb, 32'h15);
    p0 = pulse_cnt;
    pulse_frame();
    wait_cycles(3);
    check("v4_sky", sky_rgb, 32'h33);
    check("v4_floor", floor_rgb, 32'h0C);
    check("v4_facing_x", facing_x, 32'h0400);
    check("v4_one_pulse", pulse_cnt - p0, 32'd1);

    // last write per address wins
    spi_send({4'h5, 16'h0111}, 20);
    spi_send({4'h5, 16'h0222}, 20);
    pulse_frame();
    wait_cycles(2);
    check("lww_vplane_y", vplane_y, 32'h0222);

    // V5: accept coincident with commit
    spi_send({4'h1, 16'h2222}, 20);
    spi_shift({4'h1, 16'h1111}, 20);
    @(negedge clk) spi_ss_n = 1'b1;
    @(negedge clk);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("v5_player_y", player_y, 32'h2222);
    check("v5_pending", pending, 32'h1);
    wait_cycles(4);
    pulse_frame();
    wait_cycles(2);
    check("v5_player_y_next", player_y, 32'h1111);
    check("v5_pending_clr", pending, 32'h0);

    // mid-transaction reset abandons the word even if ss_n stays low
    spi_ss_n = 1'b0;
    #40;
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    spi_shift({4'h0, 16'h7777}, 20);
    spi_ss_n = 1'b1;
    #120;
    check("rst_mid_pending", pending, 32'h0);
    check("rst_mid_player_x", player_x, 32'h1800);
`else
    // V3: bad lengths dropped
    spi_send({4'h0, 16'hFFFF}, 19);
    spi_send({5'h0, 16'hFFFF}, 21);
    check("v3_player_x", player_x, 32'h1800);
    check("v3_no_pulse", pulse_cnt, 32'd0);

    // V6: immediate write
    p0 = pulse_cnt;
    spi_send({4'h4, 16'h0300}, 20);
    check("v6_vplane_x", vplane_x, 32'h0300);
    check("v6_pending", pending, 32'h0);
    check("v6_one_pulse", pulse_cnt - p0, 32'd1);

    // colours and an ignored address
    spi_send({4'h6, 16'h0C33}, 20);
    check("imm_sky", sky_rgb, 32'h33);
    check("imm_floor", floor_rgb, 32'h0C);
    p0 = pulse_cnt;
    spi_send({4'h7, 16'h1234}, 20);
    check("addr7_no_pulse", pulse_cnt - p0, 32'd0);
    check("addr7_player_x", player_x, 32'h1800);

    // frame_start ignored
    p0 = pulse_cnt;
    pulse_frame();
    wait_cycles(3);
    check("frame_no_pulse", pulse_cnt - p0, 32'd0);
    spi_send({4'h3, 16'h8001}, 20);
    check("imm_facing_y", facing_y, 32'h8001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
